// File: rtl/serial_subtractor.sv
// Bit-serial SIZE-bit subtractor: computes A - B - bin one bit per clock, LSB first,
// with a start/busy/done handshake and registered diff, borrow-out and overflow.
module serial_subtractor #(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    input  logic            bin,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] diff,
    output logic            bout,
    output logic            ovf
);

    localparam int CNT_W = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [SIZE-1:0]   a_sh_q, a_sh_d;
    logic [SIZE-1:0]   b_sh_q, b_sh_d;
    // Holds the SIZE-1 bits already produced; the final bit joins them on the way to diff.
    logic [SIZE-2:0]   res_sh_q, res_sh_d;
    logic              borrow_q, borrow_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   diff_q, diff_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;

    logic              bit_a, bit_b, bit_d, br_next, last_bit;
    logic [SIZE-1:0]   res_next;

    // Single full-subtractor cell shared across all bit positions.
    assign bit_a    = a_sh_q[0];
    assign bit_b    = b_sh_q[0];
    assign bit_d    = bit_a ^ bit_b ^ borrow_q;
    assign br_next  = (~bit_a & bit_b) | (~bit_a & borrow_q) | (bit_b & borrow_q);
    assign res_next = {bit_d, res_sh_q};
    assign last_bit = (cnt_q == LAST_BIT);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so statement order inside this block cannot change behaviour.
    // NOTE: the shift registers are plain flops rather than a memory array,
    // so they are reset along with everything else to keep idle state defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in a comb block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = start ? SHIFT : IDLE;
            SHIFT:      state_d = last_bit ? DONE : SHIFT;
            default:    state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    borrow_d = bin;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next[SIZE-1:1];
                borrow_d = br_next;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // On the last bit the shifted operands expose their MSBs at bit 0.
                    diff_d = res_next;
                    bout_d = br_next;
                    ovf_d  = (bit_a != bit_b) && (bit_d != bit_a);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at SIZE=4 and SIZE=8: vector table,
// scoreboard queues popped on done, and hand sequences for multi-cycle corners.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } exp_t;

    typedef struct {
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, bin4, busy4, done4, bout4, ovf4;
    logic [3:0] a4, b4, diff4;
    logic       start8, bin8, busy8, done8, bout8, ovf8;
    logic [7:0] a8, b8, diff8;

    int   total = 0;
    int   bad   = 0;
    exp_t q4[$];
    exp_t q8[$];
    exp_t e4, e8;
    int   pushed[2] = '{0, 0};
    int   pulses[2] = '{0, 0};
    int   overlap   = 0;
    logic [7:0] prev_exp[2] = '{8'h0, 8'h0};

    serial_subtractor #(.SIZE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    serial_subtractor #(.SIZE(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model from integer arithmetic, independent of the bit-serial structure.
    function automatic exp_t model(input int n, input int a, input int b, input int bin);
        exp_t m;
        int   half = 1 << (n - 1);
        int   d    = a - b - bin;
        int   sa   = (a >= half) ? a - (1 << n) : a;
        int   sb   = (b >= half) ? b - (1 << n) : b;
        int   sd   = sa - sb - bin;
        m.diff = 8'(d & ((1 << n) - 1));
        m.bout = (d < 0);
        m.ovf  = (sd < -half) || (sd > half - 1);
        return m;
    endfunction

    function automatic logic dut_busy(input logic sel);
        return sel ? busy8 : busy4;
    endfunction

    function automatic logic dut_done(input logic sel);
        return sel ? done8 : done4;
    endfunction

    function automatic logic [7:0] dut_diff(input logic sel);
        return sel ? diff8 : {4'h0, diff4};
    endfunction

    // Scoreboard: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (busy4 && done4) overlap++;
        if (busy8 && done8) overlap++;
        if (done4) begin
            pulses[0]++;
            if (q4.size() == 0) check("unexpected_done4", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("diff4", {28'h0, diff4}, {24'h0, e4.diff[3:0]});
                check("bout4", {31'h0, bout4}, {31'h0, e4.bout});
                check("ovf4",  {31'h0, ovf4},  {31'h0, e4.ovf});
            end
        end
        if (done8) begin
            pulses[1]++;
            if (q8.size() == 0) check("unexpected_done8", 1, 0);
            else begin
                e8 = q8.pop_front();
                check("diff8", {24'h0, diff8}, {24'h0, e8.diff});
                check("bout8", {31'h0, bout8}, {31'h0, e8.bout});
                check("ovf8",  {31'h0, ovf8},  {31'h0, e8.ovf});
            end
        end
    end

    // Called #1 after an edge with the DUT idle or in its done cycle; returns
    // #1 after the done edge. start stays high for 'hold' edges with scrambled operands.
    task automatic run_op(input logic sel, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input exp_t e, input int hold);
        int lat = 0;
        int busy_cyc = 0;
        int n = sel ? 8 : 4;
        logic stale_ok = 1'b1;
        if (sel) begin a8 = a; b8 = b; bin8 = bin; start8 = 1'b1; q8.push_back(e); end
        else begin a4 = a[3:0]; b4 = b[3:0]; bin4 = bin; start4 = 1'b1; q4.push_back(e); end
        pushed[sel]++;
        @(posedge clk); #1;
        check("done_clear_after_start", {31'h0, dut_done(sel)}, 0);
        if (sel) begin a8 = ~a; b8 = ~b; bin8 = ~bin; end
        else begin a4 = ~a[3:0]; b4 = ~b[3:0]; bin4 = ~bin; end
        if (hold <= 1) begin start4 = 1'b0; start8 = 1'b0; end
        while (!dut_done(sel) && lat < 40) begin
            if (dut_busy(sel)) begin
                busy_cyc++;
                if (dut_diff(sel) !== prev_exp[sel]) stale_ok = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (lat + 1 >= hold) begin start4 = 1'b0; start8 = 1'b0; end
        end
        check("latency", lat, n);
        check("busy_cycles", busy_cyc, n);
        check("diff_held_while_busy", {31'h0, stale_ok}, 1);
        check("busy_low_at_done", {31'h0, dut_busy(sel)}, 0);
        prev_exp[sel] = e.diff;
    endtask

    vec_t vecs[$];

    initial begin
        exp_t m;
        vec_t v;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;

        // Vector table: fixed corner cases then random operands through the model.
        vecs.push_back('{1'b0, 8'd9, 8'd3, 1'b0, '{8'h6, 1'b0, 1'b1}});
        vecs.push_back('{1'b0, 8'd3, 8'd9, 1'b0, '{8'hA, 1'b1, 1'b1}});
        vecs.push_back('{1'b0, 8'd8, 8'd1, 1'b0, '{8'h7, 1'b0, 1'b1}});
        vecs.push_back('{1'b0, 8'd0, 8'd0, 1'b1, '{8'hF, 1'b1, 1'b0}});
        vecs.push_back('{1'b1, 8'h00, 8'hFF, 1'b0, '{8'h01, 1'b1, 1'b0}});
        vecs.push_back('{1'b1, 8'h80, 8'h01, 1'b0, '{8'h7F, 1'b0, 1'b1}});
        for (int i = 0; i < 10; i++) begin
            v.sel = (i >= 6);
            v.a   = v.sel ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            v.b   = v.sel ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            v.bin = 1'($urandom_range(0, 1));
            v.e   = model(v.sel ? 8 : 4, int'(v.a), int'(v.b), int'(v.bin));
            vecs.push_back(v);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy4", {31'h0, busy4}, 0);
        check("rst_done4", {31'h0, done4}, 0);
        check("rst_diff4", {28'h0, diff4}, 0);
        check("rst_bout_ovf4", {30'h0, bout4, ovf4}, 0);
        check("rst_diff8", {24'h0, diff8}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].e, 1);
            if (i % 3 == 0) begin @(posedge clk); #1; end
        end

        // start held high while busy, then restart in the done cycle.
        @(posedge clk); #1;
        run_op(1'b0, 8'd5, 8'd2, 1'b0, '{8'h3, 1'b0, 1'b0}, 3);
        run_op(1'b0, 8'd2, 8'd5, 1'b0, '{8'hD, 1'b1, 1'b0}, 1);

        // Abort after bit 2 of 15-1: reset wins, no done.
        @(posedge clk); #1;
        a4 = 4'd15; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {31'h0, busy4}, 0);
        check("abort_done", {31'h0, done4}, 0);
        check("abort_diff", {28'h0, diff4}, 0);
        check("abort_bout_ovf", {30'h0, bout4, ovf4}, 0);
        rst = 1'b0;
        prev_exp[0] = 8'h0;
        prev_exp[1] = 8'h0;
        repeat (3) begin @(posedge clk); #1; end
        check("abort_no_done", {31'h0, done4}, 0);
        run_op(1'b0, 8'd15, 8'd1, 1'b0, '{8'hE, 1'b0, 1'b0}, 1);

        repeat (3) @(posedge clk);
        #1;
        check("q4_drained", q4.size(), 0);
        check("q8_drained", q8.size(), 0);
        check("pulses4", pulses[0], pushed[0]);
        check("pulses8", pulses[1], pushed[1]);
        check("busy_done_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
